fifo_multi_cond: RTL
====================

// Module: fifo_multi_cond
// PURPOSE
//  Multi-channel conditioned FIFO: NCH independent FIFOs (one per PCIe virtual channel/class), each with
//  parametrised width/depth, programmable almost-full/almost-empty thresholds, registered read data with valid,
//  per-channel fill level and sticky overrun/underrun errors. Sits between the class demux and the arbiter;
//  fifo_pause feeds back-pressure to the upstream source.
// PARAMETERS
//  BW     6   data width per channel (bits)
//  DEPTH  16  entries per channel, any value >= 2 (power of two not required)
//  NCH    4   number of channels
//  CW     localparam = $clog2(DEPTH+1), fill/threshold width
//  AW     localparam = $clog2(DEPTH), pointer width
// PORTS
//  clk               in   1       clock, all logic on rising edge
//  reset_L           in   1       asynchronous active-low reset
//  fifo_wr           in   NCH     write request, bit i -> channel i
//  fifo_data_in      in   NCH*BW  write data, channel i at [i*BW +: BW]
//  fifo_rd           in   NCH     read request, bit i -> channel i
//  umbral_bajo       in   CW      almost-empty threshold (shared by all channels)
//  umbral_alto       in   CW      almost-full threshold (shared by all channels)
//  err_clear         in   1       synchronous clear of sticky error flags
//  fifo_data_out     out  NCH*BW  registered read data, channel i at [i*BW +: BW]
//  fifo_valid        out  NCH     fifo_data_out slice i valid this cycle
//  fifo_full         out  NCH     fill == DEPTH
//  fifo_empty        out  NCH     fill == 0
//  fifo_almost_full  out  NCH     fill >= umbral_alto
//  fifo_almost_empty out  NCH     fill <= umbral_bajo
//  fifo_fill         out  NCH*CW  occupancy, channel i at [i*CW +: CW]
//  fifo_pause        out  1       OR of fifo_almost_full
//  error_vec         out  NCH     sticky per-channel error (overrun | underrun)
//  error_output      out  1       OR of error_vec
// BEHAVIOUR
//  - Reset (reset_L low, immediate, any time incl. mid-transfer): pointers, fill, data_out, valid, errors = 0;
//    hence empty=1, full=0, almost_empty=1, almost_full=(umbral_alto==0), pause likewise. Memory not reset.
//  - Flags are combinational from registered fill and live thresholds; threshold changes take effect same cycle.
//  - Write accepted iff fifo_wr & (!full | fifo_rd). Accepted write: mem[wrptr]<=data, wrptr wraps DEPTH-1 -> 0.
//  - Write while full without read: data dropped, wrptr/fill unchanged, overrun set.
//  - Read accepted iff fifo_rd & !empty. Next cycle: data_out slice = mem[old rdptr], valid=1; rdptr wraps
//    DEPTH-1 -> 0. Read latency exactly 1 cycle.
//  - Read while empty: underrun set, valid=0 next cycle; a same-cycle write still succeeds (fill 0 -> 1),
//    no bypass of write data to read data.
//  - Cycle with no accepted read: valid=0 and data_out slice = 0.
//  - Fill: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither.
//    Full with simultaneous rd+wr: both accepted, fill stays DEPTH. Fill never exceeds DEPTH or goes below 0.
//  - Errors sticky until err_clear. err_clear with new error in same cycle: flag stays set (set wins).
//  - Channels fully independent; no cross-channel ordering or shared storage.
// STRUCTURE
//  - Include file fifo_defs.vh: width helper (clog2 function) and default BW/DEPTH/NCH localparams
//    shared with arbiter and demux.
//  - Sub-module fifo_chan: single-channel core (mem, pointers, fill, flags, sticky error, registered output).
//    Instantiated NCH times via generate. Top level does slicing plus OR reduction for fifo_pause/error_output.
// TESTING (defaults BW=6, DEPTH=16, NCH=4, umbral_bajo=2, umbral_alto=14)
//  1 Reset: after release, all empty=1, almost_empty=1, full=0, pause=0, fill=0, valid=0, error_output=0;
//    assert reset_L mid-burst -> same values immediately, asynchronous to clk.
//  2 Ch0 write 0x01..0x10 (16 words) -> almost_full at fill=14, full at 16, pause=1; 17th write -> overrun,
//    error_vec=4'b0001; read 16 -> data 0x01..0x10 in order, each 1 cycle after rd, valid high.
//  3 Wrap: 10 writes, 10 reads, 10 more writes/reads on ch2 -> pointers wrap past 15, data intact, fill back to 0.
//  4 Full + simultaneous rd/wr on ch1 -> fill stays 16, no overrun, head word out, new word stored at tail.
//  5 Empty ch3: rd+wr same cycle -> underrun, valid=0, fill=1; err_clear with no new error -> error_vec=0;
//    err_clear with new underrun -> bit remains 1.
//  6 Concurrent traffic on all 4 channels with distinct data patterns -> no cross-channel corruption; reduce
//    umbral_alto to 3 mid-run -> almost_full/pause update same cycle.

Source files
------------

// File: rtl/fifo_multi_cond_pkg.sv
// Shared definitions for the conditioned FIFO slice: default geometry and a
// constant-evaluable width helper used to size pointers and fill counters.
package fifo_multi_cond_pkg;

   localparam int DEF_BW    = 6;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_NCH   = 4;

   // Smallest r with 2**r >= v; usable in parameter expressions.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_multi_cond_chan.sv
// Single-channel FIFO core: storage, wrapping pointers, fill counter,
// threshold flags, sticky overrun/underrun and a registered read port.
module fifo_chan
   import fifo_multi_cond_pkg::*;
#(
   parameter int BW    = DEF_BW,
   parameter int DEPTH = DEF_DEPTH,
   localparam int CW   = clog2(DEPTH + 1),
   localparam int AW   = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          wr,
   input  logic [BW-1:0] data_in,
   input  logic          rd,
   input  logic [CW-1:0] umbral_bajo,
   input  logic [CW-1:0] umbral_alto,
   input  logic          err_clear,
   output logic [BW-1:0] data_out,
   output logic          valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [CW-1:0] fill,
   output logic          error
);

   logic [BW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] fill_reg, fill_next;
   logic [BW-1:0] data_out_reg;
   logic          valid_reg;
   logic          error_reg, error_next;
   logic          wr_ok, rd_ok, overrun, underrun;

   // Pointer advance with wrap for non-power-of-two depths.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Flags follow the registered fill and the live thresholds.
   assign full         = (fill_reg == CW'(DEPTH));
   assign empty        = (fill_reg == '0);
   assign almost_full  = (fill_reg >= umbral_alto);
   assign almost_empty = (fill_reg <= umbral_bajo);

   // A read frees a slot, so a full FIFO may still accept a write alongside it.
   assign rd_ok    = rd & ~empty;
   assign wr_ok    = wr & (~full | rd);
   assign overrun  = wr & full & ~rd;
   assign underrun = rd & empty;

   // Next fill and sticky error; a fresh error wins over a clear.
   always_comb begin
      fill_next  = fill_reg;
      error_next = (error_reg & ~err_clear) | overrun | underrun;
      case ({wr_ok, rd_ok})
         2'b10:   fill_next = fill_reg + CW'(1);
         2'b01:   fill_next = fill_reg - CW'(1);
         default: fill_next = fill_reg;
      endcase
   end

   // Storage write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_reg] <= data_in;
   end

   // Control state and registered read data (zero when no read is accepted).
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fill_reg     <= '0;
         data_out_reg <= '0;
         valid_reg    <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (rd_ok) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         fill_reg     <= fill_next;
         data_out_reg <= rd_ok ? mem[rd_ptr_reg] : '0;
         valid_reg    <= rd_ok;
         error_reg    <= error_next;
      end
   end

   assign data_out = data_out_reg;
   assign valid    = valid_reg;
   assign fill     = fill_reg;
   assign error    = error_reg;

endmodule

// File: rtl/fifo_multi_cond.sv
// Multi-channel conditioned FIFO: one independent fifo_chan per virtual
// channel, flat bus slicing, and OR-reduced back-pressure / error summary.
module fifo_multi_cond
   import fifo_multi_cond_pkg::*;
#(
   parameter int BW    = DEF_BW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int NCH   = DEF_NCH,
   localparam int CW   = clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [NCH-1:0]    fifo_wr,
   input  logic [NCH*BW-1:0] fifo_data_in,
   input  logic [NCH-1:0]    fifo_rd,
   input  logic [CW-1:0]     umbral_bajo,
   input  logic [CW-1:0]     umbral_alto,
   input  logic              err_clear,
   output logic [NCH*BW-1:0] fifo_data_out,
   output logic [NCH-1:0]    fifo_valid,
   output logic [NCH-1:0]    fifo_full,
   output logic [NCH-1:0]    fifo_empty,
   output logic [NCH-1:0]    fifo_almost_full,
   output logic [NCH-1:0]    fifo_almost_empty,
   output logic [NCH*CW-1:0] fifo_fill,
   output logic              fifo_pause,
   output logic [NCH-1:0]    error_vec,
   output logic              error_output
);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      fifo_chan #(.BW(BW), .DEPTH(DEPTH)) u_chan (
         .clk          (clk),
         .reset_L      (reset_L),
         .wr           (fifo_wr[gi]),
         .data_in      (fifo_data_in[gi*BW +: BW]),
         .rd           (fifo_rd[gi]),
         .umbral_bajo  (umbral_bajo),
         .umbral_alto  (umbral_alto),
         .err_clear    (err_clear),
         .data_out     (fifo_data_out[gi*BW +: BW]),
         .valid        (fifo_valid[gi]),
         .full         (fifo_full[gi]),
         .empty        (fifo_empty[gi]),
         .almost_full  (fifo_almost_full[gi]),
         .almost_empty (fifo_almost_empty[gi]),
         .fill         (fifo_fill[gi*CW +: CW]),
         .error        (error_vec[gi])
      );
   end

   assign fifo_pause   = |fifo_almost_full;
   assign error_output = |error_vec;

endmodule
